// File: rtl/sweeper_pkg.sv
// Shared types and sizing constants for the truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;

endpackage

// File: rtl/sweeper_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while enabled, then wraps to 0.
module hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last_cycle
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_cnt;

    assign last_cycle = (hold_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else if (enable) begin
            if (last_cycle) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors, checks f against EXPECTED at the end of each hold window.
// Optional first-failure log enabled by defining SWEEP_ERRLOG_EN.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int          HOLD_CYCLES = 5,
    parameter logic [15:0] EXPECTED    = 16'h6996
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             f,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef SWEEP_ERRLOG_EN
    ,
    output logic [3:0]       first_fail_idx,
    output logic             any_fail
`endif
);

    state_t           state;
    logic             last_cycle;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    // vec_idx is forced to 0 outside RUN, so the DUT inputs read 0 in IDLE/DONE.
    assign {a, b, c, d} = vec_idx;

    always_comb begin
        mismatch = (f != EXPECTED[vec_idx]);
        err_next = err_count + ERR_W'(mismatch);
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state != RUN),
        .enable    (state == RUN),
        .last_cycle(last_cycle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef SWEEP_ERRLOG_EN
            first_fail_idx <= '0;
            any_fail       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        vec_idx   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
`ifdef SWEEP_ERRLOG_EN
                        first_fail_idx <= '0;
                        any_fail       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        err_count <= err_next;
`ifdef SWEEP_ERRLOG_EN
                        if (mismatch && !any_fail) begin
                            first_fail_idx <= vec_idx;
                            any_fail       <= 1'b1;
                        end
`endif
                        // pass uses err_next so the last vector's result is included.
                        if (vec_idx == VEC_W'(NUM_VEC - 1)) begin
                            state   <= DONE;
                            vec_idx <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next == '0);
                        end else begin
                            vec_idx <= vec_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: HOLD_CYCLES=5 instance (golden / stuck-at-0 DUT) and HOLD_CYCLES=1 instance (inverted DUT).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start5 = 1'b0;
    logic start1 = 1'b0;
    int   mode5 = 0;  // 0: golden parity DUT, 1: f stuck at 0

    logic       a5, b5, c5, d5, busy5, done5, pass5, f5;
    logic [3:0] vec5;
    logic [4:0] err5;
    logic       a1, b1, c1, d1, busy1, done1, pass1, f1;
    logic [3:0] vec1;
    logic [4:0] err1;
`ifdef SWEEP_ERRLOG_EN
    logic [3:0] ffi5, ffi1;
    logic       anyf5, anyf1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign f5 = (mode5 == 1) ? 1'b0 : (a5 ^ b5 ^ c5 ^ d5);
    assign f1 = ~(a1 ^ b1 ^ c1 ^ d1);

    truth_table_sweeper #(
        .HOLD_CYCLES(5),
        .EXPECTED   (16'h6996)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .f(f5),
        .a(a5), .b(b5), .c(c5), .d(d5), .vec_idx(vec5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err5)
`ifdef SWEEP_ERRLOG_EN
        , .first_fail_idx(ffi5), .any_fail(anyf5)
`endif
    );

    truth_table_sweeper #(
        .HOLD_CYCLES(1),
        .EXPECTED   (16'h6996)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef SWEEP_ERRLOG_EN
        , .first_fail_idx(ffi1), .any_fail(anyf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start5 for one edge; returns on the negedge of the first RUN cycle.
    task automatic begin5();
        @(negedge clk);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
    endtask

    // Walks the 80 RUN cycles, counting cycles with wrong vector/flags; returns on the first DONE negedge.
    task automatic sweep5(input int pulse_at, output int bad);
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            start5 = (k == pulse_at);
            if (vec5 !== 4'(k / 5) || {a5, b5, c5, d5} !== 4'(k / 5) ||
                busy5 !== 1'b1 || done5 !== 1'b0)
                bad++;
        end
        @(negedge clk);
        start5 = 1'b0;
    endtask

    initial begin
        int bad;

        // Reset state
        #2;
        check("reset_outs5", {a5, b5, c5, d5, vec5, busy5, done5, pass5, err5}, 0);
        check("reset_outs1", {a1, b1, c1, d1, vec1, busy1, done1, pass1, err1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Golden DUT sweep
        mode5 = 0;
        begin5();
        sweep5(-1, bad);
        check("golden_hold_pattern", bad, 0);
        check("golden_done", done5, 1);
        check("golden_busy", busy5, 0);
        check("golden_err", err5, 0);
        check("golden_pass", pass5, 1);
        check("golden_done_vec", {a5, b5, c5, d5, vec5}, 0);
`ifdef SWEEP_ERRLOG_EN
        check("golden_any_fail", anyf5, 0);
`endif
        repeat (3) @(negedge clk);
        check("golden_hold_result", {done5, pass5, err5}, {2'b11, 5'd0});

        // Stuck-at-0 DUT, restarted from DONE, with a stray start at cycle 20
        mode5 = 1;
        begin5();
        sweep5(20, bad);
        check("stuck_hold_pattern", bad, 0);
        check("stuck_done", done5, 1);
        check("stuck_err", err5, 8);
        check("stuck_pass", pass5, 0);
`ifdef SWEEP_ERRLOG_EN
        check("stuck_first_fail", ffi5, 1);
        check("stuck_any_fail", anyf5, 1);
`endif

        // Start in DONE clears results and restarts from vector 0
        mode5 = 0;
        @(negedge clk);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        check("restart_err_clear", err5, 0);
        check("restart_done_drop", done5, 0);
        check("restart_vec0", vec5, 0);
`ifdef SWEEP_ERRLOG_EN
        check("restart_any_fail_clear", anyf5, 0);
`endif
        bad = 0;
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            if (vec5 !== 4'(k / 5) || busy5 !== 1'b1 || done5 !== 1'b0) bad++;
        end
        @(negedge clk);
        check("restart_hold_pattern", bad, 0);
        check("restart_result", {done5, pass5, err5}, {2'b11, 5'd0});

        // Asynchronous reset mid-sweep at vector 7
        begin5();
        for (int k = 1; k <= 35; k++) @(negedge clk);
        check("pre_reset_vec7", vec5, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {a5, b5, c5, d5, vec5, busy5, done5, pass5, err5}, 0);
        check("async_reset_state", u_dut5.state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin5();
        check("post_reset_vec0", vec5, 0);
        bad = 0;
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            if (vec5 !== 4'(k / 5) || busy5 !== 1'b1 || done5 !== 1'b0) bad++;
        end
        @(negedge clk);
        check("post_reset_hold_pattern", bad, 0);
        check("post_reset_result", {done5, pass5, err5}, {2'b11, 5'd0});

        // HOLD_CYCLES=1 with inverted DUT: one vector per cycle, every vector fails
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (vec1 !== 4'(k) || {a1, b1, c1, d1} !== 4'(k) || busy1 !== 1'b1 || done1 !== 1'b0)
                bad++;
        end
        @(negedge clk);
        check("hold1_pattern", bad, 0);
        check("hold1_done", done1, 1);
        check("hold1_err", err1, 16);
        check("hold1_pass", pass1, 0);
`ifdef SWEEP_ERRLOG_EN
        check("hold1_first_fail", ffi1, 0);
        check("hold1_any_fail", anyf1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
